// File: rtl/lsu_issue_queue_if.sv
// Bundle of dispatch, CDB, issue and flush signals around the LSU issue queue.
//   slave  : the issue queue side (consumes dispatch/CDB/lsu_ready, produces issue/count)
//   master : the environment side (dispatch stage, CDB, LSU)
interface lsu_issue_queue_if #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ROB_TAG_W = 4,
    parameter int unsigned PREG_W    = 6
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                 flush_i;
    logic                 disp_valid_i;
    logic                 disp_ready_o;
    logic                 disp_mem_read_i;
    logic                 disp_rs1_rdy_i;
    logic [PREG_W-1:0]    disp_rs1_tag_i;
    logic [31:0]          disp_rs1_val_i;
    logic [31:0]          disp_imm_i;
    logic [PREG_W-1:0]    disp_rd_p_i;
    logic [ROB_TAG_W-1:0] disp_rob_tag_i;
    logic                 cdb_valid_i;
    logic [PREG_W-1:0]    cdb_tag_i;
    logic [31:0]          cdb_val_i;
    logic                 lsu_ready_i;
    logic                 issue_valid_o;
    logic                 issue_mem_read_o;
    logic [31:0]          issue_rs1_val_o;
    logic [31:0]          issue_imm_o;
    logic [PREG_W-1:0]    issue_rd_p_o;
    logic [ROB_TAG_W-1:0] issue_rob_tag_o;
    logic [CNT_W-1:0]     count_o;

    modport slave (
        input  flush_i, disp_valid_i, disp_mem_read_i, disp_rs1_rdy_i, disp_rs1_tag_i,
               disp_rs1_val_i, disp_imm_i, disp_rd_p_i, disp_rob_tag_i,
               cdb_valid_i, cdb_tag_i, cdb_val_i, lsu_ready_i,
        output disp_ready_o, issue_valid_o, issue_mem_read_o, issue_rs1_val_o, issue_imm_o,
               issue_rd_p_o, issue_rob_tag_o, count_o
    );

    modport master (
        output flush_i, disp_valid_i, disp_mem_read_i, disp_rs1_rdy_i, disp_rs1_tag_i,
               disp_rs1_val_i, disp_imm_i, disp_rd_p_i, disp_rob_tag_i,
               cdb_valid_i, cdb_tag_i, cdb_val_i, lsu_ready_i,
        input  disp_ready_o, issue_valid_o, issue_mem_read_o, issue_rs1_val_o, issue_imm_o,
               issue_rd_p_o, issue_rob_tag_o, count_o
    );
endinterface

// File: rtl/lsu_issue_queue.sv
// In-order issue queue for memory ops between dispatch and the load/store unit.
// Buffers ops in a circular buffer, captures base operands from the CDB, and offers the
// oldest op to the LSU once its base is ready. Only the head may issue.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (priority over flush)
//   bus  - lsu_issue_queue_if.slave: flush, dispatch, CDB, issue handshake, occupancy
module lsu_issue_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ROB_TAG_W = 4,
    parameter int unsigned PREG_W    = 6
) (
    input logic               clk,
    input logic               rst,
    lsu_issue_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                 mem_read [DEPTH];
    logic                 rs1_rdy  [DEPTH];
    logic [PREG_W-1:0]    rs1_tag  [DEPTH];
    logic [31:0]          rs1_val  [DEPTH];
    logic [31:0]          imm      [DEPTH];
    logic [PREG_W-1:0]    rd_p     [DEPTH];
    logic [ROB_TAG_W-1:0] rob_tag  [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;

    logic             disp_ready;
    logic             issue_valid;
    logic             enq;
    logic             fire;
    logic             bypass;
    logic [DEPTH-1:0] occupied;

    // Readiness depends only on registered count, so a full queue never accepts even
    // when the head fires in the same cycle.
    assign disp_ready  = (count < CNT_W'(DEPTH));
    assign issue_valid = (count != '0) && rs1_rdy[head_ptr];
    assign enq         = bus.disp_valid_i && disp_ready;
    assign fire        = issue_valid && bus.lsu_ready_i;
    assign bypass      = bus.cdb_valid_i && !bus.disp_rs1_rdy_i &&
                         (bus.disp_rs1_tag_i == bus.cdb_tag_i);

    // Entry i is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = (CNT_W'(PTR_W'(i) - head_ptr) < count);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_read[i] <= 1'b0;
                rs1_rdy[i]  <= 1'b0;
                rs1_tag[i]  <= '0;
                rs1_val[i]  <= '0;
                imm[i]      <= '0;
                rd_p[i]     <= '0;
                rob_tag[i]  <= '0;
            end
        end else if (bus.flush_i) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rs1_rdy[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.cdb_valid_i && occupied[i] && !rs1_rdy[i] &&
                    (rs1_tag[i] == bus.cdb_tag_i)) begin
                    rs1_rdy[i] <= 1'b1;
                    rs1_val[i] <= bus.cdb_val_i;
                end
            end

            // The tail slot is never occupied when enq fires, so these writes never
            // collide with the wakeup or the head clear above.
            if (fire) begin
                rs1_rdy[head_ptr] <= 1'b0;
                head_ptr          <= head_ptr + 1'b1;
            end

            if (enq) begin
                mem_read[tail_ptr] <= bus.disp_mem_read_i;
                rs1_rdy[tail_ptr]  <= bus.disp_rs1_rdy_i || bypass;
                rs1_tag[tail_ptr]  <= bus.disp_rs1_tag_i;
                rs1_val[tail_ptr]  <= bypass ? bus.cdb_val_i : bus.disp_rs1_val_i;
                imm[tail_ptr]      <= bus.disp_imm_i;
                rd_p[tail_ptr]     <= bus.disp_rd_p_i;
                rob_tag[tail_ptr]  <= bus.disp_rob_tag_i;
                tail_ptr           <= tail_ptr + 1'b1;
            end

            unique case ({enq, fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.disp_ready_o     = disp_ready;
    assign bus.issue_valid_o    = issue_valid;
    assign bus.issue_mem_read_o = mem_read[head_ptr];
    assign bus.issue_rs1_val_o  = rs1_val[head_ptr];
    assign bus.issue_imm_o      = imm[head_ptr];
    assign bus.issue_rd_p_o     = rd_p[head_ptr];
    assign bus.issue_rob_tag_o  = rob_tag[head_ptr];
    assign bus.count_o          = count;
endmodule

// File: tb/tb_lsu_issue_queue.sv
// Directed bench for lsu_issue_queue: reset state, ready-at-dispatch issue, CDB wakeup
// latency, dispatch/CDB bypass, full queue with pointer wrap, in-order blocking, flush.
module tb_lsu_issue_queue;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    lsu_issue_queue_if #(.DEPTH(4), .ROB_TAG_W(4), .PREG_W(6)) bus ();

    lsu_issue_queue #(.DEPTH(4), .ROB_TAG_W(4), .PREG_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic rd, input logic rdy, input logic [5:0] tag,
                        input logic [31:0] val, input logic [31:0] off,
                        input logic [5:0] rdp, input logic [3:0] rob);
        bus.disp_valid_i    = 1'b1;
        bus.disp_mem_read_i = rd;
        bus.disp_rs1_rdy_i  = rdy;
        bus.disp_rs1_tag_i  = tag;
        bus.disp_rs1_val_i  = val;
        bus.disp_imm_i      = off;
        bus.disp_rd_p_i     = rdp;
        bus.disp_rob_tag_i  = rob;
    endtask

    initial begin
        rst                 = 1'b1;
        bus.flush_i         = 1'b0;
        bus.disp_valid_i    = 1'b0;
        bus.disp_mem_read_i = 1'b0;
        bus.disp_rs1_rdy_i  = 1'b0;
        bus.disp_rs1_tag_i  = '0;
        bus.disp_rs1_val_i  = '0;
        bus.disp_imm_i      = '0;
        bus.disp_rd_p_i     = '0;
        bus.disp_rob_tag_i  = '0;
        bus.cdb_valid_i     = 1'b0;
        bus.cdb_tag_i       = '0;
        bus.cdb_val_i       = '0;
        bus.lsu_ready_i     = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_disp_ready", 32'(bus.disp_ready_o), 32'd1);
        check("rst_issue_valid", 32'(bus.issue_valid_o), 32'd0);
        check("rst_count", 32'(bus.count_o), 32'd0);
        check("rst_rs1_val", bus.issue_rs1_val_o, 32'd0);
        check("rst_imm", bus.issue_imm_o, 32'd0);
        check("rst_rd_p", 32'(bus.issue_rd_p_o), 32'd0);
        check("rst_rob", 32'(bus.issue_rob_tag_o), 32'd0);
        check("rst_mem_read", 32'(bus.issue_mem_read_o), 32'd0);

        // Ready load into empty queue: offered the cycle after dispatch
        disp(1'b1, 1'b1, 6'd0, 32'h100, 32'h4, 6'd5, 4'd3);
        tick();
        bus.disp_valid_i = 1'b0;
        check("t1_valid", 32'(bus.issue_valid_o), 32'd1);
        check("t1_val", bus.issue_rs1_val_o, 32'h100);
        check("t1_imm", bus.issue_imm_o, 32'h4);
        check("t1_rd_p", 32'(bus.issue_rd_p_o), 32'd5);
        check("t1_rob", 32'(bus.issue_rob_tag_o), 32'd3);
        check("t1_mem_read", 32'(bus.issue_mem_read_o), 32'd1);
        check("t1_count", 32'(bus.count_o), 32'd1);
        tick();
        check("t1_empty_count", 32'(bus.count_o), 32'd0);
        check("t1_empty_valid", 32'(bus.issue_valid_o), 32'd0);

        // Wakeup via CDB three cycles after dispatch, issue one cycle after broadcast
        disp(1'b0, 1'b0, 6'd12, 32'h0, 32'h8, 6'd6, 4'd1);
        tick();
        bus.disp_valid_i = 1'b0;
        check("t2_wait0", 32'(bus.issue_valid_o), 32'd0);
        check("t2_count", 32'(bus.count_o), 32'd1);
        tick();
        check("t2_wait1", 32'(bus.issue_valid_o), 32'd0);
        tick();
        check("t2_wait2", 32'(bus.issue_valid_o), 32'd0);
        bus.cdb_valid_i = 1'b1;
        bus.cdb_tag_i   = 6'd12;
        bus.cdb_val_i   = 32'hABC;
        #1;
        check("t2_no_comb_wake", 32'(bus.issue_valid_o), 32'd0);
        tick();
        bus.cdb_valid_i = 1'b0;
        check("t2_woken_valid", 32'(bus.issue_valid_o), 32'd1);
        check("t2_woken_val", bus.issue_rs1_val_o, 32'hABC);
        check("t2_woken_mem_read", 32'(bus.issue_mem_read_o), 32'd0);
        tick();
        check("t2_drained", 32'(bus.count_o), 32'd0);

        // Dispatch/CDB same-cycle bypass
        disp(1'b1, 1'b0, 6'd7, 32'hDEAD, 32'h0, 6'd2, 4'd4);
        bus.cdb_valid_i = 1'b1;
        bus.cdb_tag_i   = 6'd7;
        bus.cdb_val_i   = 32'h55;
        tick();
        bus.disp_valid_i = 1'b0;
        bus.cdb_valid_i  = 1'b0;
        check("t3_bypass_valid", 32'(bus.issue_valid_o), 32'd1);
        check("t3_bypass_val", bus.issue_rs1_val_o, 32'h55);
        tick();
        check("t3_drained", 32'(bus.count_o), 32'd0);

        // Fill with LSU stalled, fifth op held off, then drain in order with wrap
        bus.lsu_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(1'b1, 1'b1, 6'd0, 32'h10 * (k + 1), 32'(k), 6'(k + 10), 4'(k + 8));
            tick();
        end
        check("t4_full_count", 32'(bus.count_o), 32'd4);
        check("t4_full_ready", 32'(bus.disp_ready_o), 32'd0);
        disp(1'b1, 1'b1, 6'd0, 32'h50, 32'h4, 6'd14, 4'd12);
        tick();
        check("t4_held_count", 32'(bus.count_o), 32'd4);
        check("t4_head_rob8", 32'(bus.issue_rob_tag_o), 32'd8);
        check("t4_head_valid", 32'(bus.issue_valid_o), 32'd1);
        bus.lsu_ready_i = 1'b1;
        tick();
        check("t4_no_enq_when_full", 32'(bus.count_o), 32'd3);
        check("t4_head_rob9", 32'(bus.issue_rob_tag_o), 32'd9);
        check("t4_ready_again", 32'(bus.disp_ready_o), 32'd1);
        tick();
        bus.disp_valid_i = 1'b0;
        check("t4_enq_fire_count", 32'(bus.count_o), 32'd3);
        check("t4_head_rob10", 32'(bus.issue_rob_tag_o), 32'd10);
        check("t4_val_rob10", bus.issue_rs1_val_o, 32'h30);
        tick();
        check("t4_head_rob11", 32'(bus.issue_rob_tag_o), 32'd11);
        check("t4_count2", 32'(bus.count_o), 32'd2);
        tick();
        check("t4_head_rob12", 32'(bus.issue_rob_tag_o), 32'd12);
        check("t4_val_rob12", bus.issue_rs1_val_o, 32'h50);
        check("t4_count1", 32'(bus.count_o), 32'd1);
        tick();
        check("t4_drained", 32'(bus.count_o), 32'd0);

        // Unready head blocks a ready younger op
        disp(1'b1, 1'b0, 6'd9, 32'h0, 32'h0, 6'd20, 4'd2);
        tick();
        disp(1'b0, 1'b1, 6'd1, 32'h77, 32'h0, 6'd21, 4'd4);
        tick();
        bus.disp_valid_i = 1'b0;
        check("t5_blocked", 32'(bus.issue_valid_o), 32'd0);
        check("t5_count", 32'(bus.count_o), 32'd2);
        tick();
        check("t5_still_blocked", 32'(bus.issue_valid_o), 32'd0);
        bus.cdb_valid_i = 1'b1;
        bus.cdb_tag_i   = 6'd9;
        bus.cdb_val_i   = 32'h99;
        tick();
        bus.cdb_valid_i = 1'b0;
        check("t5_head_valid", 32'(bus.issue_valid_o), 32'd1);
        check("t5_head_rob", 32'(bus.issue_rob_tag_o), 32'd2);
        check("t5_head_val", bus.issue_rs1_val_o, 32'h99);
        tick();
        check("t5_young_valid", 32'(bus.issue_valid_o), 32'd1);
        check("t5_young_rob", 32'(bus.issue_rob_tag_o), 32'd4);
        check("t5_young_val", bus.issue_rs1_val_o, 32'h77);
        tick();
        check("t5_drained", 32'(bus.count_o), 32'd0);

        // Flush overrides a same-cycle dispatch
        bus.lsu_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            disp(1'b1, 1'b1, 6'd0, 32'h200, 32'h0, 6'd30, 4'(k));
            tick();
        end
        check("t6_count3", 32'(bus.count_o), 32'd3);
        disp(1'b1, 1'b1, 6'd0, 32'h300, 32'h0, 6'd31, 4'd5);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i      = 1'b0;
        bus.disp_valid_i = 1'b0;
        check("t6_flush_count", 32'(bus.count_o), 32'd0);
        check("t6_flush_valid", 32'(bus.issue_valid_o), 32'd0);
        check("t6_flush_ready", 32'(bus.disp_ready_o), 32'd1);
        tick();
        check("t6_dropped", 32'(bus.count_o), 32'd0);

        // Queue works normally after flush
        bus.lsu_ready_i = 1'b1;
        disp(1'b0, 1'b1, 6'd0, 32'h400, 32'h10, 6'd1, 4'd6);
        tick();
        bus.disp_valid_i = 1'b0;
        check("t7_after_flush_valid", 32'(bus.issue_valid_o), 32'd1);
        check("t7_after_flush_rob", 32'(bus.issue_rob_tag_o), 32'd6);
        tick();
        check("t7_drained", 32'(bus.count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_issue_queue.md
Name: lsu_issue_queue

Overview:
- In-order issue queue for memory operations. Sits between dispatch/rename and the load/store functional unit.
- Buffers memory ops, captures base-register operands from the CDB as they are broadcast, and issues the oldest op to the LSU once its base is ready and the LSU asserts ready.
- Strict program-order issue: no op bypasses an older, not-yet-ready op.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2, ≥2.
- ROB_TAG_W, 4, ROB tag width.
- PREG_W, 6, physical register tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  discard all entries (mispredict recovery).
- disp_valid_i  in  1  dispatch request.
- disp_ready_o  out  1  queue can accept; 1 when count < DEPTH.
- disp_mem_read_i  in  1  op is a load.
- disp_rs1_rdy_i  in  1  base operand already available.
- disp_rs1_tag_i  in  PREG_W  base operand physical tag.
- disp_rs1_val_i  in  32  base value; valid when disp_rs1_rdy_i=1.
- disp_imm_i  in  32  sign-extended offset.
- disp_rd_p_i  in  PREG_W  destination physical register.
- disp_rob_tag_i  in  ROB_TAG_W  ROB tag.
- cdb_valid_i  in  1  CDB broadcast valid.
- cdb_tag_i  in  PREG_W  broadcast physical tag.
- cdb_val_i  in  32  broadcast value.
- lsu_ready_i  in  1  LSU can accept an op this cycle.
- issue_valid_o  out  1  head entry is offered to the LSU.
- issue_mem_read_o  out  1  head mem_read.
- issue_rs1_val_o  out  32  head base value.
- issue_imm_o  out  32  head offset.
- issue_rd_p_o  out  PREG_W  head destination.
- issue_rob_tag_o  out  ROB_TAG_W  head ROB tag.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Storage: circular buffer.
  - head_ptr and tail_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count register is 0..DEPTH.
  - Each entry holds mem_read, rs1_rdy, rs1_tag, rs1_val, imm, rd_p, rob_tag.
- Reset (rst=1 at posedge):
  - Pointers and count cleared; all entry rs1_rdy cleared; all storage zeroed.
  - Following reset: disp_ready_o=1, issue_valid_o=0, count_o=0, issue payload outputs 0.
- Dispatch:
  - Enqueue fires when disp_valid_i && disp_ready_o; the entry is written at tail_ptr and tail_ptr advances.
  - disp_ready_o depends only on registered count. When full, a same-cycle issue does not free a slot for a same-cycle dispatch.
- Wakeup: every posedge with cdb_valid_i, each occupied entry with rs1_rdy=0 and rs1_tag==cdb_tag_i sets rs1_rdy=1 and rs1_val=cdb_val_i.
- Dispatch/CDB bypass: an enqueuing op with disp_rs1_rdy_i=0 and tag equal to the same-cycle CDB broadcast is written with rs1_rdy=1 and rs1_val=cdb_val_i.
- Issue:
  - issue_valid_o = (count≠0) && head.rs1_rdy. This is a combinational function of registered state only.
  - Payload outputs are driven combinationally from the head entry at all times.
  - Fire = issue_valid_o && lsu_ready_i. On fire, head_ptr advances and the entry's rs1_rdy is cleared.
  - A head entry woken this cycle issues no earlier than the next cycle, so issue latency from CDB broadcast is 1 cycle.
  - An op dispatched with rs1 ready into an empty queue is offered on the cycle after dispatch.
- Ordering: only the head may issue; younger ready entries wait.
- Count update:
  - +1 on enqueue only; −1 on fire only; unchanged when both occur or neither occurs.
  - Simultaneous enqueue and fire at count=DEPTH cannot occur, because disp_ready_o=0.
- Flush: flush_i at posedge clears pointers, count and all rs1_rdy, overriding same-cycle dispatch, issue and wakeup. A fire asserted in the flush cycle is still seen by the LSU; the discard is handled downstream.
- rst has priority over flush_i.
- issue_mem_read_o is passed through unmodified. Store handling downstream is outside this block.

Test Plan:
- Reset, then dispatch load {rs1_rdy=1, val=0x100, imm=0x4, rd_p=5, rob=3} with lsu_ready_i=1 -> next cycle issue_valid_o=1, rs1_val=0x100, imm=0x4, rd_p=5, rob=3; queue empties the cycle after.
- Dispatch op with rs1_rdy=0, tag=12; CDB broadcasts tag=12, val=0xABC 3 cycles later -> issue_valid_o rises exactly 1 cycle after the broadcast with rs1_val=0xABC.
- Dispatch with tag=7 not ready while CDB broadcasts tag=7, val=0x55 in the same cycle -> entry captured ready; issued next cycle with 0x55.
- Hold lsu_ready_i=0 and dispatch 5 ready ops -> first 4 accepted, disp_ready_o=0 on the 5th, count_o=4. Release lsu_ready_i -> issue order matches dispatch order by rob_tag, pointers wrap correctly, and the 5th op is accepted once count drops.
- Head not ready (tag=9) with a ready younger entry behind it -> issue_valid_o stays 0 until tag 9 is broadcast, then the head issues first and the younger op issues the following cycle.
- Fill 3 entries, assert flush_i together with a dispatch -> count_o=0 and issue_valid_o=0 next cycle, and the dispatched op is dropped.
